// File: rtl/timer_pkg.sv
// Shared definitions for the timer interrupt controller.
//   - register map addresses on the 8-bit CPU bus
//   - bit positions inside CTRL and STATUS
//   - control FSM state encoding
package timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_COUNT  = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  localparam int ST_IF   = 0;
  localparam int ST_OVR  = 1;
  localparam int ST_BUSY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: CPU-facing control stage for an external timer.
// Counts timer timeouts up to PERIOD, then raises a sticky IF flag and,
// if enabled, an interrupt. Runs one-shot (AUTO=0) or periodic (AUTO=1).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   addr/we/re      register select, 1-cycle write / read strobes
//   wdata, rdata    write data, registered read data (valid cycle after re)
//   tmr_start       1-cycle pulse that starts the timer
//   tmr_tout        1-cycle timeout pulse from the timer
//   irq             registered IF & IE
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter logic [7:0] RST_PERIOD = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] addr,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       tmr_start,
  input  logic       tmr_tout,
  output logic       irq
);

  state_t     state, state_nxt;
  logic       en, auto_rl, ie, if_f, ovr;
  logic [7:0] period, cnt;

  logic       ctrl_wr, per_wr, stat_wr;
  logic       stop, go, hit, last;
  logic [8:0] pe;

  assign ctrl_wr = we && (addr == ADDR_CTRL);
  assign per_wr  = we && (addr == ADDR_PERIOD);
  assign stat_wr = we && (addr == ADDR_STATUS);

  // Stop beats everything, including a timeout arriving the same cycle.
  assign stop = ctrl_wr && !wdata[CTRL_EN];
  // EN=1 while already enabled is not a restart.
  assign go   = ctrl_wr && wdata[CTRL_EN] && !en;
  assign hit  = (state == WAIT) && tmr_tout && !stop;

  // PERIOD==0 encodes 256; compare with >= so a PERIOD lowered mid-run
  // below the current count still terminates on the next timeout.
  assign pe   = (period == 8'd0) ? 9'd256 : {1'b0, period};
  assign last = hit && (({1'b0, cnt} + 9'd1) >= pe);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (go) state_nxt = ARM;
        ARM:     state_nxt = WAIT;
        WAIT:    if (hit) state_nxt = (last && !auto_rl) ? IDLE : ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    tmr_start = (state == ARM);
  end

  // Register file, counter and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      period  <= RST_PERIOD;
      cnt     <= 8'd0;
      if_f    <= 1'b0;
      ovr     <= 1'b0;
      rdata   <= 8'd0;
      irq     <= 1'b0;
    end else begin
      // Reads sample pre-write values, so a same-cycle write is not visible.
      if (re) begin
        case (addr)
          ADDR_CTRL:   rdata <= {5'd0, ie, auto_rl, en};
          ADDR_PERIOD: rdata <= period;
          ADDR_STATUS: rdata <= {5'd0, state != IDLE, ovr, if_f};
          ADDR_COUNT:  rdata <= cnt;
          default:     rdata <= 8'd0;
        endcase
      end

      irq <= if_f & ie;

      if (ctrl_wr) begin
        auto_rl <= wdata[CTRL_AUTO];
        ie      <= wdata[CTRL_IE];
        if (stop)    en <= 1'b0;
        else if (go) en <= 1'b1;
      end
      // One-shot completion drops EN even over a concurrent EN=1 write.
      if (last && !auto_rl) en <= 1'b0;

      if (per_wr) period <= wdata;

      if (go)       cnt <= 8'd0;
      else if (hit) cnt <= last ? 8'd0 : cnt + 8'd1;

      // W1C, with a same-cycle set taking priority; OVR uses pre-clear IF.
      if_f <= (if_f & ~(stat_wr & wdata[ST_IF]))  | last;
      ovr  <= (ovr  & ~(stat_wr & wdata[ST_OVR])) | (last & if_f);
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Scoreboard bench for timer_irq_ctrl. A small timer model (MAX_COUNT=8)
// answers each tmr_start with a timeout 8 cycles later. A transaction-level
// reference model predicts registers, tmr_start and irq; read expectations
// are queued at issue time and checked by an independent monitor.
module tb_timer_irq_ctrl;
  import timer_pkg::*;

  localparam int MAX_COUNT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] addr = 2'd0;
  logic       we = 1'b0, re = 1'b0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata;
  logic       tmr_start, tmr_tout = 1'b0, irq;

  timer_irq_ctrl #(.RST_PERIOD(8'd1)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .wdata(wdata),
    .rdata(rdata), .tmr_start(tmr_start), .tmr_tout(tmr_tout), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_en, m_auto, m_ie, m_if, m_ovr, m_start, m_irq;
  int m_period, m_cnt;
  int tcnt;
  int nstart;

  logic [7:0] expq[$];
  logic       re_q = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mread(input logic [1:0] a);
    case (a)
      ADDR_CTRL:   mread = {5'd0, m_ie, m_auto, m_en};
      ADDR_PERIOD: mread = 8'(m_period);
      ADDR_STATUS: mread = {5'd0, m_en, m_ovr, m_if};  // busy exactly while enabled
      default:     mread = 8'(m_cnt);
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_ie = 0; m_if = 0; m_ovr = 0;
    m_start = 0; m_irq = 0; m_period = 1; m_cnt = 0; tcnt = 0;
  endtask

  // One cycle of the spec's rules, applied to the values before the edge.
  task automatic model_update(input logic w, input logic [1:0] a,
                              input logic [7:0] d, input logic tv);
    bit o_if, o_en, o_pend, o_auto, fin, waiting;
    int pe;
    o_if = m_if; o_en = m_en; o_pend = m_start; o_auto = m_auto;
    m_irq = m_if & m_ie;
    waiting = o_en && !o_pend;
    fin = 0;
    m_start = 0;
    if (w && a == ADDR_CTRL) begin m_auto = d[1]; m_ie = d[2]; end
    if (w && a == ADDR_CTRL && !d[0]) begin
      m_en = 0;
    end else if (w && a == ADDR_CTRL && d[0] && !o_en) begin
      m_en = 1; m_cnt = 0; m_start = 1;
    end else if (waiting && tv) begin
      pe = (m_period == 0) ? 256 : m_period;
      if (m_cnt + 1 >= pe) begin
        fin = 1; m_cnt = 0;
        if (o_auto) m_start = 1; else m_en = 0;
      end else begin
        m_cnt = m_cnt + 1; m_start = 1;
      end
    end
    if (w && a == ADDR_STATUS) begin
      if (d[0]) m_if = 0;
      if (d[1]) m_ovr = 0;
    end
    if (fin) begin
      if (o_if) m_ovr = 1;
      m_if = 1;
    end
    if (w && a == ADDR_PERIOD) m_period = int'(d);
  endtask

  // Called at a negedge: check outputs, drive one cycle, advance the model.
  task automatic step(input logic w, input logic r, input logic [1:0] a,
                      input logic [7:0] d, input logic ft,
                      input logic ov, input logic [7:0] ovv);
    logic tv;
    chk("tmr_start", int'(tmr_start), int'(m_start));
    chk("irq", int'(irq), int'(m_irq));
    if (tmr_start) nstart++;
    tv = 1'b0;
    if (tcnt > 0) begin tcnt--; tv = (tcnt == 0); end
    if (tmr_start) tcnt = MAX_COUNT;
    tv = tv | ft;
    we = w; re = r; addr = a; wdata = d; tmr_tout = tv;
    if (r) expq.push_back(ov ? ovv : mread(a));
    model_update(w, a, d, tv);
    @(negedge clk);
  endtask

  task automatic idle(input int n = 1);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 8'd0, 0, 0, 8'd0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(1, 0, a, d, 0, 0, 8'd0);
  endtask
  task automatic rdx(input logic [1:0] a, input logic [7:0] v);
    step(0, 1, a, 8'd0, 0, 1, v);
  endtask

  task automatic do_reset();
    rst = 1; we = 0; re = 0; tmr_tout = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  // monitor: compares rdata the cycle after each accepted read
  always @(posedge clk) re_q <= re && !rst;
  initial begin
    forever begin
      @(negedge clk);
      if (re_q) begin
        if (expq.size() == 0) begin
          chk("rdata_unexpected", 1, 0);
        end else begin
          chk("rdata", int'(rdata), int'(expq.pop_front()));
        end
      end
    end
  end

  initial begin
    int g;
    logic [1:0] a;
    logic [7:0] d;
    model_reset();
    @(negedge clk);
    do_reset();
    rdx(ADDR_CTRL, 8'h00); rdx(ADDR_PERIOD, 8'h01);
    rdx(ADDR_STATUS, 8'h00); rdx(ADDR_COUNT, 8'h00);
    idle();

    // 1: one-shot, PERIOD=3
    nstart = 0;
    wr(ADDR_PERIOD, 8'd3); wr(ADDR_CTRL, 8'h01);
    for (g = 0; g < 200 && m_en; g++) idle();
    chk("t1_done", int'(m_en), 0);
    idle(20);
    chk("t1_starts", nstart, 3);
    rdx(ADDR_STATUS, 8'h01); rdx(ADDR_CTRL, 8'h00); idle();

    // 2: periodic with irq, PERIOD=2
    do_reset();
    wr(ADDR_PERIOD, 8'd2); wr(ADDR_CTRL, 8'h07);
    for (g = 0; g < 200 && !m_if; g++) idle();
    chk("t2_irq_lag", int'(irq), 0);
    idle();
    chk("t2_irq_rise", int'(irq), 1);
    wr(ADDR_STATUS, 8'h01);
    idle();
    chk("t2_irq_clr", int'(irq), 0);
    for (g = 0; g < 400 && !m_ovr; g++) idle();
    chk("t2_ovr_seen", int'(m_ovr), 1);
    rdx(ADDR_STATUS, 8'h07);
    wr(ADDR_CTRL, 8'h00); idle(2);

    // 3: PERIOD=0 means 256 timeouts
    do_reset();
    wr(ADDR_PERIOD, 8'd0); wr(ADDR_CTRL, 8'h01);
    for (g = 0; g < 4000 && !(m_cnt == 255 && m_en && !m_start); g++) idle();
    rdx(ADDR_COUNT, 8'd255); rdx(ADDR_STATUS, 8'h04);
    for (g = 0; g < 50 && m_en; g++) idle();
    idle();
    rdx(ADDR_STATUS, 8'h01); idle();

    // 4: stop in the same cycle as a timeout
    do_reset();
    wr(ADDR_PERIOD, 8'd5); wr(ADDR_CTRL, 8'h01);
    for (g = 0; g < 200 && !(m_cnt == 2 && m_en && !m_start); g++) idle();
    step(1, 0, ADDR_CTRL, 8'h00, 1, 0, 8'd0);
    rdx(ADDR_COUNT, 8'd2); rdx(ADDR_STATUS, 8'h00); rdx(ADDR_CTRL, 8'h00);
    idle(12);

    // 5: W1C in the same cycle as the IF set
    do_reset();
    wr(ADDR_PERIOD, 8'd1); wr(ADDR_CTRL, 8'h01);
    idle();                                       // ARM cycle
    step(1, 0, ADDR_STATUS, 8'h03, 1, 0, 8'd0);  // final timeout + W1C
    rdx(ADDR_STATUS, 8'h01); idle(12);

    // 6: reset during WAIT with cnt=5, then a late timeout
    do_reset();
    wr(ADDR_PERIOD, 8'd10); wr(ADDR_CTRL, 8'h05);
    for (g = 0; g < 300 && !(m_cnt == 5 && m_en && !m_start); g++) idle();
    do_reset();
    chk("t6_start", int'(tmr_start), 0);
    rdx(ADDR_CTRL, 8'h00); rdx(ADDR_PERIOD, 8'h01);
    rdx(ADDR_STATUS, 8'h00); rdx(ADDR_COUNT, 8'h00);
    step(0, 0, 2'd0, 8'd0, 1, 0, 8'd0);
    idle();
    rdx(ADDR_STATUS, 8'h00); rdx(ADDR_COUNT, 8'h00); idle();

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      a = 2'($urandom_range(0, 3));
      case (a)
        ADDR_CTRL:   d = 8'($urandom_range(0, 7)) | 8'(($urandom % 4) != 0);
        ADDR_PERIOD: d = 8'($urandom_range(0, 4));
        default:     d = 8'($urandom);
      endcase
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(($urandom % 10) == 0, ($urandom % 6) == 0, a, d,
                ($urandom % 40) == 0, 0, 8'd0);
    end
    idle(2);
    chk("queue_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
